// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
// The block itself takes the slave view; the operand source/result sink takes master.
interface pipelined_add_sub_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into STAGES equal
// chunks with one register stage each, valid/ready on both sides with full backpressure.
module pipelined_add_sub #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_add_sub_if.slave bus
);
    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : gen_bad_param
        $error("pipelined_add_sub: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
    end

    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_move;
    logic [STAGES:0]   w_take;
    logic [STAGES-1:0] w_carry;
    logic [WIDTH-1:0]  w_sum [STAGES];
    logic [WIDTH-1:0]  w_a   [STAGES];
    logic [WIDTH-1:0]  w_b   [STAGES];
    logic [WIDTH-1:0]  w_b_cond;

    assign w_b_cond = bus.sub ? ~bus.b : bus.b;

    // The consumer acts as stage STAGES; readiness ripples back one stage per loop step.
    always_comb begin
        w_take         = '0;
        w_move         = '0;
        w_take[STAGES] = bus.out_ready;
        for (int k = int'(LAST); k >= 0; k--) begin
            w_move[k] = w_valid[k] & w_take[k+1];
            w_take[k] = ~w_valid[k] | w_move[k];
        end
    end

    assign w_load       = w_take[STAGES-1:0];
    assign bus.in_ready = rst_n & w_load[0];

    for (genvar k = 0; k < int'(STAGES); k++) begin : gen_stage
        logic             w_src_v;
        logic             w_src_c;
        logic [WIDTH-1:0] w_src_a;
        logic [WIDTH-1:0] w_src_b;
        logic [WIDTH-1:0] w_src_sum;
        logic [WIDTH-1:0] w_new_sum;
        logic [CW:0]      w_chunk;
        logic             r_valid;
        logic             r_carry;
        logic [WIDTH-1:0] r_sum;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;

        if (k == 0) begin : gen_head
            assign w_src_v   = bus.in_valid;
            assign w_src_c   = bus.sub;
            assign w_src_a   = bus.a;
            assign w_src_b   = w_b_cond;
            assign w_src_sum = '0;
        end else begin : gen_body
            assign w_src_v   = w_valid[k-1];
            assign w_src_c   = w_carry[k-1];
            assign w_src_a   = w_a[k-1];
            assign w_src_b   = w_b[k-1];
            assign w_src_sum = w_sum[k-1];
        end

        assign w_chunk = {1'b0, w_src_a[k*CW +: CW]} + {1'b0, w_src_b[k*CW +: CW]}
                       + {{CW{1'b0}}, w_src_c};

        always_comb begin
            w_new_sum                = w_src_sum;
            w_new_sum[k*CW +: CW]    = w_chunk[CW-1:0];
        end

        // Data registers only capture real beats so an emptied stage keeps its last result.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
                r_a     <= '0;
                r_b     <= '0;
            end else if (w_load[k]) begin
                r_valid <= w_src_v;
                if (w_src_v) begin
                    r_carry <= w_chunk[CW];
                    r_sum   <= w_new_sum;
                    r_a     <= w_src_a;
                    r_b     <= w_src_b;
                end
            end
        end

        assign w_valid[k] = r_valid;
        assign w_carry[k] = r_carry;
        assign w_sum[k]   = r_sum;
        assign w_a[k]     = r_a;
        assign w_b[k]     = r_b;
    end

    assign bus.out_valid = w_valid[LAST];
    assign bus.sum       = w_sum[LAST];
    assign bus.carry_out = w_carry[LAST];
    assign bus.overflow  = (w_a[LAST][WIDTH-1] == w_b[LAST][WIDTH-1])
                         && (w_sum[LAST][WIDTH-1] != w_a[LAST][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed vectors on 8x2, exhaustive 3x1, random 8x8 with a
// queue-based reference of a + (sub ? ~b : b) + sub.
module tb_pipelined_add_sub;
    localparam int N_RAND = 10000;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    int          n_acc;
    int          n_out;
    logic [7:0]  bp_sum_q[$];
    int          bp_cyc_q[$];
    logic [9:0]  exp_q[$];
    logic        pend;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;
    int          sent;
    int          got;
    int          cyc;
    logic [3:0]  t3;
    logic [2:0]  va;
    logic [2:0]  vb;
    logic        ovf3;

    pipelined_add_sub_if #(.WIDTH(8)) if_8x2 ();
    pipelined_add_sub_if #(.WIDTH(3)) if_3x1 ();
    pipelined_add_sub_if #(.WIDTH(8)) if_8x8 ();

    pipelined_add_sub #(.WIDTH(8), .STAGES(2)) u_dut_8x2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_8x2)
    );

    pipelined_add_sub #(.WIDTH(3), .STAGES(1)) u_dut_3x1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_3x1)
    );

    pipelined_add_sub #(.WIDTH(8), .STAGES(8)) u_dut_8x8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_8x8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] bq;
        logic [8:0] t;
        bq = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bq} + 9'(s);
        return {(a[7] == bq[7]) && (t[7] != a[7]), t[8], t[7:0]};
    endfunction

    // Called at a negedge with the 8x2 pipe empty; returns at a negedge with it empty again.
    task automatic run_8x2(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [7:0] e_sum, input logic e_c,
                           input logic e_ovf);
        int lat;
        if_8x2.a         = a;
        if_8x2.b         = b;
        if_8x2.sub       = s;
        if_8x2.in_valid  = 1'b1;
        if_8x2.out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(if_8x2.in_ready), 32'd1);
        @(negedge clk);
        if_8x2.in_valid = 1'b0;
        lat = 1;
        while (!if_8x2.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_sum"}, 32'(if_8x2.sum), 32'(e_sum));
        check({tag, "_carry"}, 32'(if_8x2.carry_out), 32'(e_c));
        check({tag, "_ovf"}, 32'(if_8x2.overflow), 32'(e_ovf));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        if_8x2.in_valid = 1'b0; if_8x2.a = '0; if_8x2.b = '0; if_8x2.sub = 1'b0;
        if_8x2.out_ready = 1'b1;
        if_3x1.in_valid = 1'b0; if_3x1.a = '0; if_3x1.b = '0; if_3x1.sub = 1'b0;
        if_3x1.out_ready = 1'b1;
        if_8x8.in_valid = 1'b0; if_8x8.a = '0; if_8x8.b = '0; if_8x8.sub = 1'b0;
        if_8x8.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(if_8x2.out_valid), 32'd0);
        check("rst_sum", 32'(if_8x2.sum), 32'd0);
        check("rst_carry", 32'(if_8x2.carry_out), 32'd0);
        check("rst_ovf", 32'(if_8x2.overflow), 32'd0);
        check("rst_in_ready", 32'(if_8x2.in_ready), 32'd0);
        check("rst_8x8_out_valid", 32'(if_8x8.out_valid), 32'd0);
        rst_n = 1'b1;

        run_8x2("wrap",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_8x2("add_ovf",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_8x2("sub_neg",  8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_8x2("sub_ovf",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_8x2("chunk_c",  8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run_8x2("sub_zero", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

        // Backpressure: consumer stalls for cycles 0-5 while four beats are offered.
        n_acc = 0;
        for (int c = 0; c < 14; c++) begin
            if_8x2.out_ready = (c >= 6);
            if_8x2.in_valid  = (n_acc < 4);
            if_8x2.a         = 8'(n_acc + 1);
            if_8x2.b         = 8'(n_acc + 1);
            if_8x2.sub       = 1'b0;
            #1;
            if (c == 2) begin
                check("bp_in_ready_low", 32'(if_8x2.in_ready), 32'd0);
                check("bp_accepted", 32'(n_acc), 32'd2);
            end
            if (c >= 2 && c < 6) begin
                check("bp_hold_valid", 32'(if_8x2.out_valid), 32'd1);
                check("bp_hold_sum", 32'(if_8x2.sum), 32'h02);
            end
            if (if_8x2.in_valid && if_8x2.in_ready) n_acc++;
            if (if_8x2.out_valid && if_8x2.out_ready) begin
                bp_sum_q.push_back(if_8x2.sum);
                bp_cyc_q.push_back(c);
            end
            @(negedge clk);
        end
        if_8x2.in_valid  = 1'b0;
        if_8x2.out_ready = 1'b1;
        check("bp_all_accepted", 32'(n_acc), 32'd4);
        check("bp_result_count", 32'(bp_sum_q.size()), 32'd4);
        for (int i = 0; i < bp_sum_q.size() && i < 4; i++) begin
            check("bp_result_sum", 32'(bp_sum_q[i]), 32'(2 * (i + 1)));
            check("bp_result_cycle", 32'(bp_cyc_q[i]), 32'(6 + i));
        end

        // Reset while a beat is in flight: it must vanish.
        if_8x2.a = 8'h10; if_8x2.b = 8'h20; if_8x2.sub = 1'b0;
        if_8x2.in_valid = 1'b1;
        @(negedge clk);
        if_8x2.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(if_8x2.out_valid), 32'd0);
        check("midrst_sum", 32'(if_8x2.sum), 32'd0);
        check("midrst_in_ready", 32'(if_8x2.in_ready), 32'd0);
        rst_n = 1'b1;
        n_out = 0;
        repeat (6) begin
            @(negedge clk);
            if (if_8x2.out_valid) n_out++;
        end
        check("midrst_no_stale", 32'(n_out), 32'd0);
        run_8x2("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Legacy 3-bit adder equivalence, one beat per cycle, latency 1.
        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                va = 3'(ia);
                vb = 3'(ib);
                if_3x1.a = va; if_3x1.b = vb; if_3x1.sub = 1'b0;
                if_3x1.in_valid = 1'b1;
                #1;
                check("add3_in_ready", 32'(if_3x1.in_ready), 32'd1);
                @(negedge clk);
                t3   = {1'b0, va} + {1'b0, vb};
                ovf3 = (va[2] == vb[2]) && (t3[2] != va[2]);
                check("add3_result",
                      32'({if_3x1.out_valid, if_3x1.overflow, if_3x1.carry_out, if_3x1.sum}),
                      32'({1'b1, ovf3, t3}));
            end
        end
        if_3x1.in_valid = 1'b0;
        @(negedge clk);

        // Random traffic on 8x8 under random backpressure.
        sent = 0; got = 0; cyc = 0; pend = 1'b0;
        ra = '0; rb = '0; rs = 1'b0;
        while (got < N_RAND && cyc < 60000) begin
            if (!pend && sent < N_RAND && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                ra   = 8'($urandom);
                rb   = 8'($urandom);
                rs   = 1'($urandom);
            end
            if_8x8.in_valid  = pend;
            if_8x8.a         = ra;
            if_8x8.b         = rb;
            if_8x8.sub       = rs;
            if_8x8.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (exp_q.size() == 8)
                check("rand_full_ready", 32'(if_8x8.in_ready), 32'(if_8x8.out_ready));
            if (if_8x8.out_valid) begin
                if (exp_q.size() == 0)
                    check("rand_spurious", 32'(if_8x8.out_valid), 32'd0);
                else
                    check("rand_result",
                          32'({if_8x8.overflow, if_8x8.carry_out, if_8x8.sum}),
                          32'(exp_q[0]));
            end
            if (if_8x8.in_valid && if_8x8.in_ready) begin
                exp_q.push_back(model8(ra, rb, rs));
                sent++;
                pend = 1'b0;
            end
            if (if_8x8.out_valid && if_8x8.out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        if_8x8.in_valid = 1'b0;
        check("rand_done", 32'(got), 32'(N_RAND));
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
